// File: rtl/dsp_file_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_file_arbiter_if
// Brief    : Engine and file-controller bus shared through dsp_file_arbiter.
// Revision : 1.0
// ============================================================================
interface dsp_file_arbiter_if #(
  parameter int NUM_ENG = 2
);
  logic [NUM_ENG-1:0]    eng_req;
  logic [NUM_ENG-1:0]    eng_done;
  logic [8*NUM_ENG-1:0]  eng_file_num;
  logic [NUM_ENG-1:0]    eng_file_read;
  logic [NUM_ENG-1:0]    eng_file_write;
  logic [32*NUM_ENG-1:0] eng_file_write_data;
  logic [NUM_ENG-1:0]    eng_enable;
  logic [NUM_ENG-1:0]    eng_file_active;
  logic [7:0]            file_num;
  logic                  file_read;
  logic                  file_write;
  logic [31:0]           file_write_data;
  logic                  file_active;
  logic [NUM_ENG-1:0]    grant;
  logic                  busy;
  logic                  timeout_err;
  logic                  interrupt;

  modport slave (
    input  eng_req, eng_done, eng_file_num, eng_file_read, eng_file_write,
           eng_file_write_data, file_active,
    output eng_enable, eng_file_active, file_num, file_read, file_write,
           file_write_data, grant, busy, timeout_err, interrupt
  );

  modport master (
    output eng_req, eng_done, eng_file_num, eng_file_read, eng_file_write,
           eng_file_write_data, file_active,
    input  eng_enable, eng_file_active, file_num, file_read, file_write,
           file_write_data, grant, busy, timeout_err, interrupt
  );
endinterface
`default_nettype wire

// File: rtl/dsp_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_file_arbiter
// Brief    : Round-robin owner of the DSP file-controller port with watchdog.
// Revision : 1.0
// ============================================================================
module dsp_file_arbiter #(
  parameter int NUM_ENG = 2,
  parameter int TIMEOUT = 65535,
  parameter int TW      = 16
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  dsp_file_arbiter_if.slave bus
);
  localparam int                 IW        = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [IW-1:0]      LAST_INIT = IW'(NUM_ENG - 1);
  localparam logic [TW-1:0]      WD_LIMIT  = TW'(TIMEOUT - 1);
  localparam logic [NUM_ENG-1:0] ONE_HOT0  = NUM_ENG'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q;
  logic [NUM_ENG-1:0] grant_q;
  logic [NUM_ENG-1:0] enable_q;
  logic [IW-1:0]      gidx_q;
  logic [IW-1:0]      last_q;
  logic [TW-1:0]      wd_q;
  logic               busy_q;
  logic               timeout_err_q;
  logic               interrupt_q;

  logic               w_found;
  logic [IW-1:0]      w_sel;
  logic [IW-1:0]      w_idx;
  logic               w_route;
  int                 w_j;

  // First requester after the last-served engine, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 1; k <= NUM_ENG; k++) begin
      w_j = int'(last_q) + k;
      if (w_j >= NUM_ENG) w_j = w_j - NUM_ENG;
      w_idx = IW'(w_j);
      if (!w_found && bus.eng_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      enable_q      <= '0;
      gidx_q        <= '0;
      last_q        <= LAST_INIT;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      interrupt_q   <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      interrupt_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_found) begin
            grant_q  <= ONE_HOT0 << w_sel;
            enable_q <= ONE_HOT0 << w_sel;
            gidx_q   <= w_sel;
            wd_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Done is tested first so a simultaneous expiry is not an error.
          if (bus.eng_done[gidx_q]) begin
            interrupt_q <= 1'b1;
            enable_q    <= '0;
            state_q     <= ST_RELEASE;
          end else if (wd_q == WD_LIMIT) begin
            timeout_err_q <= 1'b1;
            enable_q      <= '0;
            state_q       <= ST_RELEASE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!bus.file_active) begin
            last_q  <= gidx_q;
            grant_q <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_route = (state_q == ST_BUSY) || (state_q == ST_RELEASE);

  // Address and data stay on the port during RELEASE; strobes do not.
  assign bus.file_num        = w_route ? bus.eng_file_num[gidx_q*8 +: 8] : 8'd0;
  assign bus.file_write_data = w_route ? bus.eng_file_write_data[gidx_q*32 +: 32] : 32'd0;
  assign bus.file_read       = (state_q == ST_BUSY) && bus.eng_file_read[gidx_q];
  assign bus.file_write      = (state_q == ST_BUSY) && bus.eng_file_write[gidx_q];
  assign bus.eng_file_active = w_route ? (grant_q & {NUM_ENG{bus.file_active}}) : '0;
  assign bus.eng_enable      = enable_q;
  assign bus.grant           = grant_q;
  assign bus.busy            = busy_q;
  assign bus.timeout_err     = timeout_err_q;
  assign bus.interrupt       = interrupt_q;
endmodule
`default_nettype wire
